multicycle_proc: RTL and testbench
==================================

MULTICYCLE_PROC -- requirements
Module: multicycle_proc

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: width of registers, bus and DIN; legal only if DATA_W >= 2*SEL_W+4.
- REQ-002 SHALL have parameter SEL_W, default 3: register-select field width; register count NREGS = 2**SEL_W.
- REQ-003 SHALL have port Clock, input, 1: single clock; all state on rising edge.
- REQ-004 SHALL have port Clear, input, 1: reset, asynchronous, active-low.
- REQ-005 SHALL have port DIN, input, DATA_W: instruction word or immediate.
- REQ-006 SHALL have port DIN_valid, input, 1: DIN holds a word.
- REQ-007 SHALL have port DIN_ready, output, 1: block accepts DIN this cycle.
- REQ-008 SHALL have port BusWires, output, DATA_W: value currently driven on the internal bus.
- REQ-009 SHALL have port Done, output, 1: one-cycle pulse on the instruction's final cycle.
- REQ-010 SHALL have port Illegal, output, 1: one-cycle pulse when an undefined opcode retires.

Function
- REQ-011 SHALL decode IR as opcode [2*SEL_W+3:2*SEL_W], X [2*SEL_W-1:SEL_W], Y [SEL_W-1:0]; upper bits ignored.
- REQ-012 SHALL run FSM states T0, T1, T2, T3, IMM.
- REQ-013 T0: DIN_ready=1; on DIN_valid, IR<=DIN and go to T1; otherwise hold in T0.
- REQ-014 Opcodes: mv 0000, mvi 0001, mvnz 0010, add 0011, sub 0100, or 0101, slt 0110, sll 0111, srl 1000.
- REQ-015 mv, T1: Rx<=Ry, Done, return to T0 (2 cycles from handshake edge inclusive).
- REQ-016 mvi, T1: go to IMM. IMM: DIN_ready=1; on DIN_valid, Rx<=DIN, Done, return to T0. Stall indefinitely without DIN_valid.
- REQ-017 ALU ops: T1 A<=Rx; T2 G<=A op Ry; T3 Rx<=G, Done, return to T0.
- REQ-018 add/sub SHALL wrap modulo 2**DATA_W.
- REQ-019 or SHALL be bitwise.
- REQ-020 slt SHALL give 1 if signed A < signed Ry, else 0.
- REQ-021 sll/srl SHALL be logical shifts of A by unsigned Ry; shift amount >= DATA_W gives 0.
- REQ-022 Z flag SHALL update on every G write: Z=1 iff new G==0.
- REQ-023 Undefined opcode (incl. mvnz when compiled out), T1: no register write, Done=1, Illegal=1, return to T0.
- REQ-024 BusWires SHALL carry Ry in T1 for mv/mvnz, Rx in T1 for ALU ops, Ry in T2, G in T3, DIN in IMM; 0 otherwise.
- REQ-025 DIN_ready SHALL be 0 in T1, T2 and T3.
- REQ-026 When X==Y, ALU ops SHALL use the same register as both operands.

Reset
- REQ-027 Clear low SHALL immediately force state T0 and clear all registers, A, G and IR.
- REQ-028 Clear low SHALL set Z=1 and drive Done, Illegal and BusWires to 0.
- REQ-029 DIN_ready SHALL be 0 while Clear is low and 1 in the first cycle after release.
- REQ-030 Reset mid-instruction SHALL abandon it with no partial register write.

Configuration
- REQ-031 With PROC_MVNZ_EN defined, mvnz in T1 SHALL write Rx<=Ry only if Z==0, then Done and return to T0.
- REQ-032 Without PROC_MVNZ_EN, opcode 0010 SHALL be treated as illegal per REQ-023.

Structure
- REQ-033 Package proc_pkg SHALL hold the opcode constants, the FSM state type and the DATA_W/SEL_W defaults.
- REQ-034 The combinational ALU SHALL be sub-module proc_alu (inputs A, B, op; output result).
- REQ-035 The register file, A, G, IR, Z and the FSM SHALL live in multicycle_proc.

Verification (DATA_W=16, SEL_W=3)
- REQ-036 Reset, then DIN=0x0040, then DIN=0x00FF -> R0=0x00FF; Done pulses in the IMM handshake cycle; DIN_ready is low for exactly 1 cycle between the two handshakes.
- REQ-037 R1=0xFFFF, R2=0x0002, DIN=0x00CA (add R1,R2) -> R1=0x0001 and Done in T3, 4 cycles after the fetch edge; Z=0.
- REQ-038 R3=0x8000, R4=0x0001, slt R3,R4 -> R3=0x0001; then R5=0x0001, R6=0x0011, sll R5,R6 -> R5=0x0000 and Z=1.
- REQ-039 With PROC_MVNZ_EN: Z=1, mvnz R0,R1 -> R0 unchanged; after an add giving non-zero G, mvnz R0,R1 -> R0=R1. Without the macro: Illegal pulses.
- REQ-040 Opcode 1111 -> Illegal and Done pulse together, all registers unchanged; Clear low during T2 of add -> Rx unchanged, next fetch executes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multicycle processor.
//   - default widths (DATA_W_DEF, SEL_W_DEF)
//   - 4-bit opcode constants
//   - FSM state type
//   - is_alu_op(): true for opcodes that take the T1/T2/T3 ALU path
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 3;

  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_MVI  = 4'h1;
  localparam logic [3:0] OP_MVNZ = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;

  typedef enum logic [2:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_IMM
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SRL);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU of the multicycle processor.
// Ports:
//   A      in  DATA_W  first operand (the A register)
//   B      in  DATA_W  second operand (the bus, carrying Ry)
//   op     in  4       opcode from IR
//   result out DATA_W  A op B; 0 for non-ALU opcodes
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result
);

  // Shift distances of DATA_W or more empty the word entirely.
  localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic                     sh_big;

  assign a_s    = A;
  assign b_s    = B;
  assign sh_big = (B >= SH_LIM);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = A + B;
      OP_SUB:  result = A - B;
      OP_OR:   result = A | B;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLL:  result = sh_big ? '0 : (A << B);
      OP_SRL:  result = sh_big ? '0 : (A >> B);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_proc.sv
// multicycle_proc: bus-based multicycle processor with 2**SEL_W registers.
// Instructions arrive on DIN with a valid/ready handshake; mvi takes its
// immediate through a second handshake.
// Ports:
//   Clock     in  1       rising-edge clock
//   Clear     in  1       asynchronous active-low reset
//   DIN       in  DATA_W  instruction word or immediate
//   DIN_valid in  1       DIN holds a word
//   DIN_ready out 1       DIN is accepted this cycle (T0 and IMM)
//   BusWires  out DATA_W  internal bus value
//   Done      out 1       pulse on an instruction's final cycle
//   Illegal   out 1       pulse when an undefined opcode retires
// Build option: define PROC_MVNZ_EN to implement mvnz; without it
// opcode 0010 retires as illegal.
module multicycle_proc
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_valid,
  output logic              DIN_ready,
  output logic [DATA_W-1:0] BusWires,
  output logic              Done,
  output logic              Illegal
);

  localparam int NREGS = 2**SEL_W;
  // Only the decoded field bits of an instruction are kept.
  localparam int IR_W  = 2*SEL_W + 4;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, g_q;
  logic [IR_W-1:0]   ir_q;
  logic              z_q;

  logic [3:0]        opcode;
  logic [SEL_W-1:0]  rx_sel, ry_sel;
  logic [DATA_W-1:0] rx_val, ry_val, bus, alu_res;
  logic              ready, done, ill;
  logic              ir_we, a_we, g_we, rf_we;

  assign opcode = ir_q[2*SEL_W+3 : 2*SEL_W];
  assign rx_sel = ir_q[2*SEL_W-1 : SEL_W];
  assign ry_sel = ir_q[SEL_W-1 : 0];
  assign rx_val = regs_q[rx_sel];
  assign ry_val = regs_q[ry_sel];

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .A      (a_q),
    .B      (bus),
    .op     (opcode),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    bus     = '0;
    ready   = 1'b0;
    done    = 1'b0;
    ill     = 1'b0;
    ir_we   = 1'b0;
    a_we    = 1'b0;
    g_we    = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      ST_T0: begin
        ready = 1'b1;
        if (DIN_valid) begin
          ir_we   = 1'b1;
          state_d = ST_T1;
        end
      end
      ST_T1: begin
        case (opcode)
          OP_MV: begin
            bus     = ry_val;
            rf_we   = 1'b1;
            done    = 1'b1;
            state_d = ST_T0;
          end
`ifdef PROC_MVNZ_EN
          OP_MVNZ: begin
            bus     = ry_val;
            rf_we   = ~z_q;
            done    = 1'b1;
            state_d = ST_T0;
          end
`endif
          OP_MVI: state_d = ST_IMM;
          default: begin
            if (is_alu_op(opcode)) begin
              bus     = rx_val;
              a_we    = 1'b1;
              state_d = ST_T2;
            end else begin
              done    = 1'b1;
              ill     = 1'b1;
              state_d = ST_T0;
            end
          end
        endcase
      end
      ST_T2: begin
        bus     = ry_val;
        g_we    = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        bus     = g_q;
        rf_we   = 1'b1;
        done    = 1'b1;
        state_d = ST_T0;
      end
      ST_IMM: begin
        ready = 1'b1;
        bus   = DIN;
        if (DIN_valid) begin
          rf_we   = 1'b1;
          done    = 1'b1;
          state_d = ST_T0;
        end
      end
      default: state_d = ST_T0;
    endcase
  end

  // The FSM sits in T0 during reset, so only DIN_ready needs Clear gating.
  assign DIN_ready = ready & Clear;
  assign BusWires  = bus;
  assign Done      = done;
  assign Illegal   = ill;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_T0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q  <= '0;
      g_q  <= '0;
      ir_q <= '0;
      z_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= DIN[IR_W-1:0];
      if (a_we)  a_q  <= bus;
      if (g_we) begin
        g_q <= alu_res;
        z_q <= (alu_res == '0);
      end
      // Every register write takes its value from the bus.
      if (rf_we) regs_q[rx_sel] <= bus;
    end
  end

endmodule

// File: tb/tb_multicycle_proc.sv
module tb_multicycle_proc;

  localparam int DW = 16;
  localparam int SW = 3;
`ifdef PROC_MVNZ_EN
  localparam bit MVNZ_EN = 1'b1;
`else
  localparam bit MVNZ_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Clear;
  logic [DW-1:0] DIN;
  logic          DIN_valid;
  logic          DIN_ready;
  logic [DW-1:0] BusWires;
  logic          Done;
  logic          Illegal;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and Z flag.
  logic [DW-1:0] ref_r [8];
  logic          ref_z;

  multicycle_proc #(.DATA_W(DW), .SEL_W(SW)) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .DIN       (DIN),
    .DIN_valid (DIN_valid),
    .DIN_ready (DIN_ready),
    .BusWires  (BusWires),
    .Done      (Done),
    .Illegal   (Illegal)
  );

  always #5 Clock = ~Clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = a | b;
      4'd6: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd7: r = (int'(b) >= DW) ? 16'd0 : (a << b);
      4'd8: r = (int'(b) >= DW) ? 16'd0 : (a >> b);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input int op, input int x, input int y);
    logic [DW-1:0] w;
    w = '0;
    w[9:6] = 4'(op);
    w[5:3] = 3'(x);
    w[2:0] = 3'(y);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    ref_z = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the block back in T0.
  task automatic do_reset();
    Clear = 1'b0;
    DIN_valid = 1'b0;
    #1;
    chk("rst_ready", DIN_ready, 0);
    chk("rst_done", Done, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_bus", BusWires, 0);
    chk("rst_z", dut.z_q, 1);
    @(posedge Clock);
    @(negedge Clock);
    Clear = 1'b1;
    @(posedge Clock);
    #1;
    chk("ready_after_rst", DIN_ready, 1);
    model_reset();
  endtask

  // Issue one instruction (and its immediate for mvi, after 'delay' stall
  // cycles) and check every cycle until it retires.
  task automatic run_instr(input logic [DW-1:0] ir, input logic [DW-1:0] imm, input int delay);
    logic [3:0]    op;
    int            x, y, dk;
    bit            ill, alu, seen, imm_phase, reads_ry;
    logic [DW-1:0] res, exp_bus;
    op  = ir[9:6];
    x   = int'(ir[5:3]);
    y   = int'(ir[2:0]);
    ill = (op > 4'd8) || (op == 4'd2 && !MVNZ_EN);
    alu = (op >= 4'd3) && (op <= 4'd8);
    reads_ry = (op == 4'd0) || (op == 4'd2 && MVNZ_EN);
    dk  = ill ? 1 : alu ? 3 : (op == 4'd1) ? 2 + delay : 1;
    res = alu ? alu_ref(op, ref_r[x], ref_r[y]) : '0;
    seen = 1'b0;

    DIN = ir;
    DIN_valid = 1'b1;
    @(negedge Clock);
    chk("fetch_ready", DIN_ready, 1);
    @(posedge Clock);
    #1;
    for (int k = 1; k <= dk + 2 && !seen; k++) begin
      imm_phase = (op == 4'd1) && !ill && (k >= 2);
      if (imm_phase && (k - 2 >= delay)) begin
        DIN = imm;
        DIN_valid = 1'b1;
      end else begin
        DIN = DW'($urandom);
        DIN_valid = imm_phase ? 1'b0 : 1'($urandom);
      end
      @(negedge Clock);
      if (k == 1)              exp_bus = reads_ry ? ref_r[y] : alu ? ref_r[x] : '0;
      else if (imm_phase)      exp_bus = DIN;
      else if (alu && k == 2)  exp_bus = ref_r[y];
      else if (alu && k == 3)  exp_bus = res;
      else                     exp_bus = '0;
      chk($sformatf("done op%0d k%0d", op, k), Done, (k == dk));
      chk($sformatf("illegal op%0d k%0d", op, k), Illegal, (k == dk) && ill);
      chk($sformatf("ready op%0d k%0d", op, k), DIN_ready, imm_phase);
      chk($sformatf("bus op%0d k%0d", op, k), BusWires, exp_bus);
      seen = Done;
      @(posedge Clock);
      #1;
    end
    DIN_valid = 1'b0;
    chk($sformatf("retired op%0d", op), seen, 1);

    if (!ill) begin
      if (op == 4'd0) ref_r[x] = ref_r[y];
      else if (op == 4'd1) ref_r[x] = imm;
      else if (op == 4'd2) begin
        if (!ref_z) ref_r[x] = ref_r[y];
      end else begin
        ref_r[x] = res;
        ref_z = (res == '0);
      end
    end
  endtask

  // mv Ri,Ri exposes Ri on the bus in T1 without changing it.
  task automatic check_regs();
    for (int i = 0; i < 8; i++) run_instr(mk(0, i, i), '0, 0);
  endtask

  task automatic check_z(input string tag);
    chk(tag, dut.z_q, ref_z);
  endtask

  initial begin
    logic [DW-1:0] w;
    int            op;
    Clear = 1'b1;
    DIN = '0;
    DIN_valid = 1'b0;
    model_reset();
    #2;
    do_reset();

    // mvi R0, 0x00FF
    run_instr(16'h0040, 16'h00FF, 0);
    run_instr(mk(0, 0, 0), '0, 0);

    // add R1,R2 with wraparound
    run_instr(mk(1, 1, 0), 16'hFFFF, 2);
    run_instr(mk(1, 2, 0), 16'h0002, 0);
    run_instr(16'h00CA, '0, 0);
    check_z("z_after_add");
    run_instr(mk(0, 1, 1), '0, 0);

    // slt signed, sll by >= DATA_W
    run_instr(mk(1, 3, 0), 16'h8000, 1);
    run_instr(mk(1, 4, 0), 16'h0001, 0);
    run_instr(mk(6, 3, 4), '0, 0);
    run_instr(mk(1, 5, 0), 16'h0001, 0);
    run_instr(mk(1, 6, 0), 16'h0011, 0);
    run_instr(mk(7, 5, 6), '0, 0);
    check_z("z_after_sll");

    // mvnz with Z=1, then after a non-zero add
    run_instr(mk(2, 0, 1), '0, 0);
    run_instr(mk(3, 2, 2), '0, 0);
    check_z("z_after_add2");
    run_instr(mk(2, 0, 1), '0, 0);

    // undefined opcode, then same-register operands
    run_instr(16'h03C9, '0, 0);
    run_instr(mk(4, 2, 2), '0, 0);
    check_z("z_after_sub_self");
    check_regs();

    // Clear during T2 of add R1,R2
    run_instr(mk(1, 1, 0), 16'h1234, 0);
    run_instr(mk(1, 2, 0), 16'h0101, 0);
    DIN = mk(3, 1, 2);
    DIN_valid = 1'b1;
    @(posedge Clock);
    #1;
    DIN_valid = 1'b0;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    chk("midrst_bus_t2", BusWires, ref_r[2]);
    do_reset();
    check_regs();
    run_instr(mk(1, 1, 0), 16'h7FFF, 0);
    run_instr(mk(1, 2, 0), 16'h0001, 0);
    run_instr(mk(3, 1, 2), '0, 0);
    run_instr(mk(0, 1, 1), '0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      w = mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      w[15:10] = 6'($urandom);
      run_instr(w, DW'($urandom), int'($urandom_range(0, 3)));
      if (n % 10 == 9) check_z($sformatf("z_rand%0d", n));
    end
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
